mux_onehot_tree: RTL and testbench

- Parameterised one-hot select multiplexer, built as a SPLIT-ary reduction tree.
- Selects one element of an array of WIDTH data words using a one-hot select vector.
- Outputs the selected word and a valid flag.
- Used wherever a one-hot grant or decode drives data selection: arbiters, crossbars, register read-back.
- Optional output register stage; clocked with asynchronous active-low reset.

---
 rtl/mux_onehot_tree.sv | 149 ++++++++++++++
 tb/tb_mux_onehot_tree.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_onehot_tree.sv
// rtl/mux_onehot_tree.sv - one-hot select multiplexer built as a SPLIT-ary reduction tree
//
// mux_onehot_tree (top)
//   clk    in   clock, only used when REGISTERED=1
//   rst_n  in   asynchronous active-low reset, only used when REGISTERED=1
//   oht    in   [WIDTH]        one-hot select, bit i selects ary[i]
//   ary    in   DAT_T [WIDTH]  data entries
//   vld    out  at least one select bit set
//   dat    out  DAT_T selected word (0 when nothing selected)
//
// mux_onehot_tree_node (recursive tree node)
//   oht/ary in, vld/dat out with the same meaning as the top, combinational only

module mux_onehot_tree_node #(
    parameter type DAT_T          = logic [7:0],
    parameter int  WIDTH          = 16,
    parameter int  SPLIT          = 4,
    parameter int  IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] oht,
    input  DAT_T             ary [WIDTH-1:0],
    output logic             vld,
    output DAT_T             dat
);

    localparam int  DW    = $bits(DAT_T);
    localparam bit  LEAF  = (WIDTH <= SPLIT);
    // Entries per sub-group; the last group keeps whatever remains.
    localparam int  CHUNK = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int  NG    = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int  N     = LEAF ? WIDTH : NG;

    // Inputs of this node's reduction: raw oht/ary at a leaf,
    // child (vld, dat) pairs at an internal node.
    logic [N-1:0]  sel;
    logic [DW-1:0] src [N-1:0];
    logic [DW-1:0] acc;

    if (LEAF) begin : g_leaf
        assign sel = oht;
        for (genvar i = 0; i < WIDTH; i++) begin : g_src
            assign src[i] = ary[i];
        end
    end else begin : g_inner
        for (genvar g = 0; g < NG; g++) begin : g_grp
            localparam int GLO = g * CHUNK;
            localparam int GW  = ((WIDTH - GLO) < CHUNK) ? (WIDTH - GLO) : CHUNK;

            DAT_T sub_ary [GW-1:0];
            logic sub_vld;
            DAT_T sub_dat;

            for (genvar k = 0; k < GW; k++) begin : g_slice
                assign sub_ary[k] = ary[GLO + k];
            end

            mux_onehot_tree_node #(
                .DAT_T          (DAT_T),
                .WIDTH          (GW),
                .SPLIT          (SPLIT),
                .IMPLEMENTATION (IMPLEMENTATION)
            ) u_child (
                .oht (oht[GLO +: GW]),
                .ary (sub_ary),
                .vld (sub_vld),
                .dat (sub_dat)
            );

            assign sel[g] = sub_vld;
            assign src[g] = sub_dat;
        end
    end

    if (IMPLEMENTATION == 1) begin : g_prio
        // Scan from the top down so the lowest-index valid input wins.
        always_comb begin
            acc = '0;
            for (int i = N - 1; i >= 0; i--) begin
                if (sel[i]) begin
                    acc = src[i];
                end
            end
        end
    end else begin : g_andor
        // Masking each entry with its own select keeps unselected X values out.
        always_comb begin
            acc = '0;
            for (int i = 0; i < N; i++) begin
                acc = acc | (src[i] & {DW{sel[i]}});
            end
        end
    end

    assign vld = |sel;
    assign dat = acc;

endmodule

module mux_onehot_tree #(
    parameter type DAT_T          = logic [7:0],
    parameter int  WIDTH          = 16,
    parameter int  SPLIT          = 4,
    parameter int  IMPLEMENTATION = 0,
    parameter bit  REGISTERED     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] oht,
    input  DAT_T             ary [WIDTH-1:0],
    output logic             vld,
    output DAT_T             dat
);

    // Any value other than 1 falls back to AND-OR.
    localparam int IMPL = (IMPLEMENTATION == 1) ? 1 : 0;

    logic tree_vld;
    DAT_T tree_dat;

    mux_onehot_tree_node #(
        .DAT_T          (DAT_T),
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPL)
    ) u_root (
        .oht (oht),
        .ary (ary),
        .vld (tree_vld),
        .dat (tree_dat)
    );

    if (REGISTERED) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                dat <= '0;
            end else begin
                vld <= tree_vld;
                dat <= tree_dat;
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign vld = tree_vld;
        assign dat = tree_dat;
    end

endmodule

// File: tb/tb_mux_onehot_tree.sv
// tb/tb_mux_onehot_tree.sv - self-checking bench for mux_onehot_tree
module tb_mux_onehot_tree;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  ary16 [15:0];
    logic [7:0]  ary10 [9:0];
    logic [15:0] o16;
    logic [9:0]  o10;
    logic [15:0] o_r;

    logic v16a, v16p, v10a, v10p, vr;
    logic [7:0] d16a, d16p, d10a, d10p, dr;

    mux_onehot_tree #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0), .REGISTERED(0)) u16a (
        .clk(clk), .rst_n(rst_n), .oht(o16), .ary(ary16), .vld(v16a), .dat(d16a));
    mux_onehot_tree #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(1), .REGISTERED(0)) u16p (
        .clk(clk), .rst_n(rst_n), .oht(o16), .ary(ary16), .vld(v16p), .dat(d16p));
    mux_onehot_tree #(.WIDTH(10), .SPLIT(4), .IMPLEMENTATION(0), .REGISTERED(0)) u10a (
        .clk(clk), .rst_n(rst_n), .oht(o10), .ary(ary10), .vld(v10a), .dat(d10a));
    mux_onehot_tree #(.WIDTH(10), .SPLIT(4), .IMPLEMENTATION(1), .REGISTERED(0)) u10p (
        .clk(clk), .rst_n(rst_n), .oht(o10), .ary(ary10), .vld(v10p), .dat(d10p));
    mux_onehot_tree #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0), .REGISTERED(1)) ur (
        .clk(clk), .rst_n(rst_n), .oht(o_r), .ary(ary16), .vld(vr), .dat(dr));

    typedef struct {
        logic [15:0] oht;
        logic        vld;
        logic [7:0]  dat0;
        logic [7:0]  dat1;
    } vec_t;

    vec_t t16[$];
    vec_t t10[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic v, input logic [7:0] d);
        check({name, " vld"}, {7'd0, vr}, {7'd0, v});
        check({name, " dat"}, dr, d);
    endtask

    initial begin
        rst_n = 1'b0;
        o16   = '0;
        o10   = '0;
        o_r   = '0;
        for (int i = 0; i < 16; i++) ary16[i] = 8'(i);
        for (int i = 0; i < 10; i++) ary10[i] = 8'hA0 + 8'(i);

        // 16-wide vectors: {oht, vld, and-or dat, priority dat}
        t16.push_back('{16'h0000, 1'b0, 8'h00, 8'h00});
        for (int i = 0; i < 16; i++) t16.push_back('{16'(1) << i, 1'b1, 8'(i), 8'(i)});
        t16.push_back('{16'h0014, 1'b1, 8'h06, 8'h02});
        t16.push_back('{16'h8001, 1'b1, 8'h0F, 8'h00});
        t16.push_back('{16'h0300, 1'b1, 8'h09, 8'h08});
        t16.push_back('{16'hFFFF, 1'b1, 8'h0F, 8'h00});

        // 10-wide uneven tree
        t10.push_back('{16'h0000, 1'b0, 8'h00, 8'h00});
        for (int i = 0; i < 10; i++) t10.push_back('{16'(1) << i, 1'b1, 8'hA0 + 8'(i), 8'hA0 + 8'(i)});
        t10.push_back('{16'h00C0, 1'b1, 8'hA7, 8'hA6});
        t10.push_back('{16'h0201, 1'b1, 8'hA9, 8'hA0});
        t10.push_back('{16'h0018, 1'b1, 8'hA7, 8'hA3});

        foreach (t16[n]) begin
            o16 = t16[n].oht;
            #1;
            check($sformatf("w16 oht=%h vld impl0", t16[n].oht), {7'd0, v16a}, {7'd0, t16[n].vld});
            check($sformatf("w16 oht=%h vld impl1", t16[n].oht), {7'd0, v16p}, {7'd0, t16[n].vld});
            check($sformatf("w16 oht=%h dat impl0", t16[n].oht), d16a, t16[n].dat0);
            check($sformatf("w16 oht=%h dat impl1", t16[n].oht), d16p, t16[n].dat1);
        end

        foreach (t10[n]) begin
            o10 = t10[n].oht[9:0];
            #1;
            check($sformatf("w10 oht=%h vld impl0", o10), {7'd0, v10a}, {7'd0, t10[n].vld});
            check($sformatf("w10 oht=%h vld impl1", o10), {7'd0, v10p}, {7'd0, t10[n].vld});
            check($sformatf("w10 oht=%h dat impl0", o10), d10a, t10[n].dat0);
            check($sformatf("w10 oht=%h dat impl1", o10), d10p, t10[n].dat1);
        end

        // Unselected X entries must not leak into the result
        ary10[3] = 8'hxx;
        ary10[9] = 8'hxx;
        o10 = 10'h020;
        #1;
        check("x-isolation impl0", d10a, 8'hA5);
        check("x-isolation impl1", d10p, 8'hA5);
        ary10[3] = 8'hA3;
        ary10[9] = 8'hA9;

        // Registered: held at zero in reset even with a live select
        o_r = 16'h0080;
        @(posedge clk); #1;
        check_reg("reg in reset", 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reg("reg after release, before edge", 1'b0, 8'h00);
        @(posedge clk); #1;
        check_reg("reg first edge", 1'b1, 8'h07);

        // Change of select only visible after the next edge
        @(negedge clk);
        o_r = 16'h0004;
        #1;
        check_reg("reg hold before edge", 1'b1, 8'h07);
        @(posedge clk); #1;
        check_reg("reg new value", 1'b1, 8'h02);
        @(negedge clk);
        o_r = 16'h0080;
        @(posedge clk); #1;
        check_reg("reg back to 7", 1'b1, 8'h07);

        // Async reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_reg("async reset immediate", 1'b0, 8'h00);
        @(posedge clk); #1;
        check_reg("held through edge in reset", 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reg("release, before edge", 1'b0, 8'h00);
        @(posedge clk); #1;
        check_reg("value one edge after release", 1'b1, 8'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
